// File: rtl/bram_image_scaler.sv
// BRAM image reader with integer zoom, placed window and border colour.
// Addresses come from incremental counters; colour and syncs leave aligned.
module bram_image_scaler #(
  parameter int          IMG_W    = 384,
  parameter int          IMG_H    = 216,
  parameter int          X_OFF    = 0,
  parameter int          Y_OFF    = 0,
  parameter int          BRAM_LAT = 2,
  parameter int          ADDR_W   = 17,
  parameter int          IDX_W    = 12,
  parameter logic [11:0] BORDER   = 12'h000,
  parameter logic        SYNC_RST = 1'b1
) (
  input  logic              clk_wiz_out,
  input  logic              reset,
  input  logic [IDX_W-1:0]  x_idx,
  input  logic [IDX_W-1:0]  y_idx,
  input  logic              video_enable,
  input  logic              h_sync_in,
  input  logic              v_sync_in,
  input  logic [2:0]        scale,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [11:0]       bram_data,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              h_sync,
  output logic              v_sync,
  output logic              frame_start
);

  localparam int XW = IDX_W + 3;

  // Window extent for a given zoom; a constant mux rather than a multiplier.
  function automatic logic [XW-1:0] span(input logic [2:0] s, input int base);
    case (s)
      3'd2:    span = XW'(base * 2);
      3'd3:    span = XW'(base * 3);
      3'd4:    span = XW'(base * 4);
      3'd5:    span = XW'(base * 5);
      3'd6:    span = XW'(base * 6);
      3'd7:    span = XW'(base * 7);
      default: span = XW'(base);
    endcase
  endfunction

  logic [2:0]        scale_r;
  logic              synced;
  logic [ADDR_W-1:0] row_base, col;
  logic [2:0]        sub_x, sub_y;

  logic              fs_now, active, in_win, first_col, last_col;
  logic [2:0]        scale_in, scale_eff;
  logic [XW-1:0]     x_ext, y_ext, x_lo, y_lo, x_hi, y_hi;
  logic [ADDR_W-1:0] row_cur, col_cur;
  logic [2:0]        sub_x_cur, sub_y_cur;

  logic [BRAM_LAT:0] vid_d, win_d, hs_d, vs_d;

  // Frame-start detection, effective zoom and window decode. The frame-start
  // cycle already uses the newly latched zoom and cleared row counters.
  always_comb begin
    fs_now    = video_enable && (x_idx == '0) && (y_idx == '0);
    scale_in  = (scale == 3'd0) ? 3'd1 : scale;
    scale_eff = fs_now ? scale_in : scale_r;
    active    = synced || fs_now;
    x_ext     = XW'(x_idx);
    y_ext     = XW'(y_idx);
    x_lo      = XW'(X_OFF);
    y_lo      = XW'(Y_OFF);
    x_hi      = x_lo + span(scale_eff, IMG_W);
    y_hi      = y_lo + span(scale_eff, IMG_H);
    in_win    = video_enable && active && (x_ext >= x_lo) && (x_ext < x_hi) &&
                (y_ext >= y_lo) && (y_ext < y_hi);
    first_col = (x_ext == x_lo);
    last_col  = (x_ext == x_hi - XW'(1));
    row_cur   = fs_now ? '0 : row_base;
    sub_y_cur = fs_now ? 3'd0 : sub_y;
    col_cur   = first_col ? '0 : col;
    sub_x_cur = first_col ? 3'd0 : sub_x;
  end

  // Zoom latch, resync flag and incremental address counters.
  always_ff @(posedge clk_wiz_out or posedge reset) begin
    if (reset) begin
      scale_r     <= 3'd1;
      synced      <= 1'b0;
      frame_start <= 1'b0;
      bram_addr   <= '0;
      row_base    <= '0;
      col         <= '0;
      sub_x       <= 3'd0;
      sub_y       <= 3'd0;
    end else begin
      frame_start <= fs_now;
      if (fs_now) begin
        scale_r <= scale_in;
        synced  <= 1'b1;
      end
      if (in_win) begin
        bram_addr <= row_cur + col_cur;
        if (sub_x_cur == scale_eff - 3'd1) begin
          sub_x <= 3'd0;
          col   <= col_cur + ADDR_W'(1);
        end else begin
          sub_x <= sub_x_cur + 3'd1;
          col   <= col_cur;
        end
      end
      if (in_win && last_col) begin
        if (sub_y_cur == scale_eff - 3'd1) begin
          sub_y    <= 3'd0;
          row_base <= row_cur + ADDR_W'(IMG_W);
        end else begin
          sub_y    <= sub_y_cur + 3'd1;
          row_base <= row_cur;
        end
      end else if (fs_now) begin
        sub_y    <= 3'd0;
        row_base <= '0;
      end
    end
  end

  // Flag delay line covering the address register and the BRAM read.
  always_ff @(posedge clk_wiz_out or posedge reset) begin
    if (reset) begin
      vid_d <= '0;
      win_d <= '0;
      hs_d  <= {(BRAM_LAT+1){SYNC_RST}};
      vs_d  <= {(BRAM_LAT+1){SYNC_RST}};
    end else begin
      vid_d <= {vid_d[BRAM_LAT-1:0], video_enable && active};
      win_d <= {win_d[BRAM_LAT-1:0], in_win};
      hs_d  <= {hs_d[BRAM_LAT-1:0], h_sync_in};
      vs_d  <= {vs_d[BRAM_LAT-1:0], v_sync_in};
    end
  end

  // Colour register: blank, border or pixel, with syncs on the same edge.
  always_ff @(posedge clk_wiz_out or posedge reset) begin
    if (reset) begin
      {red, green, blue} <= 12'h000;
      h_sync             <= SYNC_RST;
      v_sync             <= SYNC_RST;
    end else begin
      if (!vid_d[BRAM_LAT])      {red, green, blue} <= 12'h000;
      else if (!win_d[BRAM_LAT]) {red, green, blue} <= BORDER;
      else                       {red, green, blue} <= bram_data;
      h_sync <= hs_d[BRAM_LAT];
      v_sync <= vs_d[BRAM_LAT];
    end
  end

endmodule

// File: tb/tb_bram_image_scaler.sv
// Directed bench: instance A has a zero-offset window, instance B a placed
// window with a red border. Both share timing inputs and see BRAM models
// that return the low 12 address bits two cycles after the address.
module tb_bram_image_scaler;

  logic        clk_wiz_out = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] x_idx = '0, y_idx = '0;
  logic        video_enable = 1'b0;
  logic        h_sync_in = 1'b1, v_sync_in = 1'b1;
  logic [2:0]  scale = 3'd5;

  logic [16:0] a_addr, b_addr;
  logic [16:0] a_q1 = '0, b_q1 = '0;
  logic [11:0] a_data = '0, b_data = '0;
  logic [3:0]  a_red, a_green, a_blue, b_red, b_green, b_blue;
  logic        a_hs, a_vs, a_fs, b_hs, b_vs, b_fs;
  logic [11:0] a_rgb, b_rgb;

  int n_cmp = 0;
  int n_err = 0;

  assign a_rgb = {a_red, a_green, a_blue};
  assign b_rgb = {b_red, b_green, b_blue};

  always #5 clk_wiz_out = ~clk_wiz_out;

  always @(posedge clk_wiz_out) begin
    a_q1   <= a_addr;
    a_data <= a_q1[11:0];
    b_q1   <= b_addr;
    b_data <= b_q1[11:0];
  end

  bram_image_scaler dut_a (
    .clk_wiz_out(clk_wiz_out), .reset(reset), .x_idx(x_idx), .y_idx(y_idx),
    .video_enable(video_enable), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .scale(scale), .bram_addr(a_addr), .bram_data(a_data), .red(a_red),
    .green(a_green), .blue(a_blue), .h_sync(a_hs), .v_sync(a_vs),
    .frame_start(a_fs)
  );

  bram_image_scaler #(.X_OFF(64), .Y_OFF(32), .BORDER(12'hF00)) dut_b (
    .clk_wiz_out(clk_wiz_out), .reset(reset), .x_idx(x_idx), .y_idx(y_idx),
    .video_enable(video_enable), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .scale(scale), .bram_addr(b_addr), .bram_data(b_data), .red(b_red),
    .green(b_green), .blue(b_blue), .h_sync(b_hs), .v_sync(b_vs),
    .frame_start(b_fs)
  );

  task automatic step(input int x, input int y, input logic ve);
    x_idx = 12'(x);
    y_idx = 12'(y);
    video_enable = ve;
    @(posedge clk_wiz_out);
    #1;
  endtask

  task automatic run_rows(input int y0, input int y1);
    for (int y = y0; y <= y1; y++) begin
      step(0, y, 1'b1);
      step(1919, y, 1'b1);
    end
  endtask

  task automatic test_reset;
    n_cmp++; if (a_addr !== 17'd0) begin n_err++; $display("FAIL reset_addr got %0d want 0", a_addr); end
    n_cmp++; if (a_rgb !== 12'h000) begin n_err++; $display("FAIL reset_rgb got %h want 000", a_rgb); end
    n_cmp++; if (a_hs !== 1'b1) begin n_err++; $display("FAIL reset_hsync got %b want 1", a_hs); end
    n_cmp++; if (a_vs !== 1'b1) begin n_err++; $display("FAIL reset_vsync got %b want 1", a_vs); end
    n_cmp++; if (a_fs !== 1'b0) begin n_err++; $display("FAIL reset_fs got %b want 0", a_fs); end
  endtask

  task automatic test_scale5;
    scale = 3'd5;
    step(0, 0, 1'b1);
    n_cmp++; if (a_fs !== 1'b1) begin n_err++; $display("FAIL s5_fs got %b want 1", a_fs); end
    n_cmp++; if (a_addr !== 17'd0) begin n_err++; $display("FAIL s5_addr_0_0 got %0d want 0", a_addr); end
    for (int x = 1; x <= 4; x++) step(x, 0, 1'b1);
    n_cmp++; if (a_fs !== 1'b0) begin n_err++; $display("FAIL s5_fs_pulse got %b want 0", a_fs); end
    n_cmp++; if (a_addr !== 17'd0) begin n_err++; $display("FAIL s5_addr_4_0 got %0d want 0", a_addr); end
    step(5, 0, 1'b1);
    n_cmp++; if (a_addr !== 17'd1) begin n_err++; $display("FAIL s5_addr_5_0 got %0d want 1", a_addr); end
    step(6, 0, 1'b1);
    step(7, 0, 1'b1);
    n_cmp++; if (a_rgb !== 12'h000) begin n_err++; $display("FAIL s5_rgb_4_0 got %h want 000", a_rgb); end
    step(8, 0, 1'b1);
    n_cmp++; if (a_rgb !== 12'h001) begin n_err++; $display("FAIL s5_rgb_5_0 got %h want 001", a_rgb); end
    for (int x = 9; x <= 1919; x++) step(x, 0, 1'b1);
    run_rows(1, 4);
    step(0, 5, 1'b1);
    n_cmp++; if (a_addr !== 17'd384) begin n_err++; $display("FAIL s5_addr_0_5 got %0d want 384", a_addr); end
    step(1919, 5, 1'b1);
    run_rows(6, 1078);
    for (int x = 0; x <= 1919; x++) step(x, 1079, 1'b1);
    n_cmp++; if (a_addr !== 17'd82943) begin n_err++; $display("FAIL s5_addr_last got %0d want 82943", a_addr); end
    step(1920, 1079, 1'b0);
    n_cmp++; if (a_addr !== 17'd82943) begin n_err++; $display("FAIL s5_addr_hold got %0d want 82943", a_addr); end
  endtask

  task automatic test_scale_change;
    scale = 3'd5;
    run_rows(0, 499);
    scale = 3'd2;
    for (int x = 0; x <= 4; x++) step(x, 500, 1'b1);
    n_cmp++; if (a_addr !== 17'd38400) begin n_err++; $display("FAIL chg_addr_4_500 got %0d want 38400", a_addr); end
    step(5, 500, 1'b1);
    n_cmp++; if (a_addr !== 17'd38401) begin n_err++; $display("FAIL chg_addr_5_500 got %0d want 38401", a_addr); end
    step(0, 0, 1'b1);
    n_cmp++; if (a_fs !== 1'b1) begin n_err++; $display("FAIL chg_fs got %b want 1", a_fs); end
    n_cmp++; if (a_addr !== 17'd0) begin n_err++; $display("FAIL chg_addr_0_0 got %0d want 0", a_addr); end
    step(1, 0, 1'b1);
    n_cmp++; if (a_addr !== 17'd0) begin n_err++; $display("FAIL chg_addr_1_0 got %0d want 0", a_addr); end
    step(2, 0, 1'b1);
    n_cmp++; if (a_addr !== 17'd1) begin n_err++; $display("FAIL chg_addr_2_0 got %0d want 1", a_addr); end
  endtask

  task automatic test_scale0;
    scale = 3'd0;
    step(0, 0, 1'b1);
    step(1, 0, 1'b1);
    n_cmp++; if (a_addr !== 17'd1) begin n_err++; $display("FAIL s0_addr_1_0 got %0d want 1", a_addr); end
    for (int x = 2; x <= 383; x++) step(x, 0, 1'b1);
    n_cmp++; if (a_addr !== 17'd383) begin n_err++; $display("FAIL s0_addr_383_0 got %0d want 383", a_addr); end
    step(384, 0, 1'b1);
    n_cmp++; if (a_addr !== 17'd383) begin n_err++; $display("FAIL s0_addr_outside got %0d want 383", a_addr); end
    step(0, 1, 1'b1);
    n_cmp++; if (a_addr !== 17'd384) begin n_err++; $display("FAIL s0_addr_0_1 got %0d want 384", a_addr); end
  endtask

  task automatic test_window;
    scale = 3'd1;
    step(0, 0, 1'b1);
    n_cmp++; if (b_fs !== 1'b1) begin n_err++; $display("FAIL win_fs got %b want 1", b_fs); end
    step(63, 32, 1'b1);
    step(64, 32, 1'b1);
    n_cmp++; if (b_addr !== 17'd0) begin n_err++; $display("FAIL win_addr_64_32 got %0d want 0", b_addr); end
    step(65, 32, 1'b1);
    step(66, 32, 1'b1);
    n_cmp++; if (b_rgb !== 12'hF00) begin n_err++; $display("FAIL win_rgb_63 got %h want F00", b_rgb); end
    step(67, 32, 1'b1);
    n_cmp++; if (b_rgb !== 12'h000) begin n_err++; $display("FAIL win_rgb_64 got %h want 000", b_rgb); end
    for (int x = 68; x <= 451; x++) begin
      step(x, 32, 1'b1);
      if (x == 447) begin
        n_cmp++; if (b_addr !== 17'd383) begin n_err++; $display("FAIL win_addr_447 got %0d want 383", b_addr); end
      end
      if (x == 450) begin
        n_cmp++; if (b_rgb !== 12'h17F) begin n_err++; $display("FAIL win_rgb_447 got %h want 17F", b_rgb); end
      end
    end
    n_cmp++; if (b_rgb !== 12'hF00) begin n_err++; $display("FAIL win_rgb_448 got %h want F00", b_rgb); end
    for (int x = 452; x <= 455; x++) step(x, 32, 1'b0);
    n_cmp++; if (b_rgb !== 12'h000) begin n_err++; $display("FAIL win_rgb_blank got %h want 000", b_rgb); end
  endtask

  task automatic test_sync;
    h_sync_in = 1'b0;
    v_sync_in = 1'b0;
    for (int i = 0; i < 3; i++) step(0, 1100, 1'b0);
    n_cmp++; if (a_hs !== 1'b1) begin n_err++; $display("FAIL sync_h_fall_early got %b want 1", a_hs); end
    n_cmp++; if (a_vs !== 1'b1) begin n_err++; $display("FAIL sync_v_fall_early got %b want 1", a_vs); end
    step(0, 1100, 1'b0);
    n_cmp++; if (a_hs !== 1'b0) begin n_err++; $display("FAIL sync_h_fall got %b want 0", a_hs); end
    n_cmp++; if (a_vs !== 1'b0) begin n_err++; $display("FAIL sync_v_fall got %b want 0", a_vs); end
    h_sync_in = 1'b1;
    v_sync_in = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 1100, 1'b0);
    n_cmp++; if (a_hs !== 1'b0) begin n_err++; $display("FAIL sync_h_rise_early got %b want 0", a_hs); end
    step(0, 1100, 1'b0);
    n_cmp++; if (a_hs !== 1'b1) begin n_err++; $display("FAIL sync_h_rise got %b want 1", a_hs); end
    n_cmp++; if (a_vs !== 1'b1) begin n_err++; $display("FAIL sync_v_rise got %b want 1", a_vs); end
  endtask

  task automatic test_reset_mid;
    scale = 3'd5;
    run_rows(0, 399);
    for (int x = 0; x <= 699; x++) begin
      if (x == 690) h_sync_in = 1'b0;
      step(x, 400, 1'b1);
    end
    step(700, 400, 1'b1);
    n_cmp++; if (a_rgb !== 12'h88B) begin n_err++; $display("FAIL rst_rgb_pre got %h want 88B", a_rgb); end
    n_cmp++; if (a_hs !== 1'b0) begin n_err++; $display("FAIL rst_hsync_pre got %b want 0", a_hs); end
    reset = 1'b1;
    #1;
    n_cmp++; if (a_rgb !== 12'h000) begin n_err++; $display("FAIL rst_rgb got %h want 000", a_rgb); end
    n_cmp++; if (a_addr !== 17'd0) begin n_err++; $display("FAIL rst_addr got %0d want 0", a_addr); end
    n_cmp++; if (a_hs !== 1'b1) begin n_err++; $display("FAIL rst_hsync got %b want 1", a_hs); end
    repeat (3) @(posedge clk_wiz_out);
    #1;
    reset = 1'b0;
    for (int x = 701; x <= 703; x++) step(x, 400, 1'b1);
    n_cmp++; if (a_hs !== 1'b1) begin n_err++; $display("FAIL rst_hsync_hold got %b want 1", a_hs); end
    step(704, 400, 1'b1);
    n_cmp++; if (a_hs !== 1'b0) begin n_err++; $display("FAIL rst_hsync_resume got %b want 0", a_hs); end
    for (int x = 705; x <= 712; x++) step(x, 400, 1'b1);
    n_cmp++; if (a_rgb !== 12'h000) begin n_err++; $display("FAIL rst_rgb_after got %h want 000", a_rgb); end
    n_cmp++; if (a_addr !== 17'd0) begin n_err++; $display("FAIL rst_addr_after got %0d want 0", a_addr); end
    h_sync_in = 1'b1;
    step(0, 0, 1'b1);
    n_cmp++; if (a_fs !== 1'b1) begin n_err++; $display("FAIL rst_fs got %b want 1", a_fs); end
    n_cmp++; if (a_addr !== 17'd0) begin n_err++; $display("FAIL rst_addr_fs got %0d want 0", a_addr); end
    for (int x = 1; x <= 5; x++) step(x, 0, 1'b1);
    n_cmp++; if (a_addr !== 17'd1) begin n_err++; $display("FAIL rst_addr_5_0 got %0d want 1", a_addr); end
  endtask

  initial begin
    repeat (3) @(posedge clk_wiz_out);
    #1;
    test_reset;
    reset = 1'b0;
    step(0, 1100, 1'b0);
    test_scale5;
    test_scale_change;
    test_scale0;
    test_window;
    test_sync;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bram_image_scaler.md
# bram_image_scaler

Parametrised BRAM image reader that replaces per-pixel divide/multiply address generation with incremental counters. It supports a run-time integer scale factor, a placed display window with a border colour, and configurable BRAM read latency. The block sits between the VGA timing controller and the colour output pins. It also delays the sync signals so that pixels and syncs leave on the same cycle.

## Interface
- IMG_W, 384: stored image width in pixels
- IMG_H, 216: stored image height in pixels
- X_OFF, 0: screen column of window left edge
- Y_OFF, 0: screen row of window top edge
- BRAM_LAT, 2: cycles from bram_addr register to valid bram_data (1..4)
- ADDR_W, 17: BRAM address width; must hold IMG_W*IMG_H-1
- IDX_W, 12: width of x_idx/y_idx
- BORDER, 12'h000: colour outside the image window while video active
- SYNC_RST, 1'b1: reset/idle level of delayed syncs
- clk_wiz_out  in  1  pixel clock
- reset  in  1  reset, asynchronous, active-high
- x_idx  in  IDX_W  current column from timing controller
- y_idx  in  IDX_W  current row from timing controller
- video_enable  in  1  active-video flag, aligned with x_idx/y_idx
- h_sync_in / v_sync_in  in  1 each  raw syncs, aligned with x_idx
- scale  in  3  integer zoom factor; 0 is treated as 1
- bram_addr  out  ADDR_W  registered read address
- bram_data  in  12  pixel word {R[11:8],G[7:4],B[3:0]}
- red / green / blue  out  4 each  registered colour
- h_sync / v_sync  out  1 each  syncs delayed to match colour
- frame_start  out  1  one-cycle pulse when scale is latched

## Operation
- Frame start is the cycle with video_enable=1, x_idx=0 and y_idx=0.
  - scale_r latches max(scale,1).
  - frame_start pulses.
  - Row counters clear: row_base=0, sub_y=0.
- scale_r stays constant for the rest of the frame; changes to scale mid-frame are ignored.
- Window condition in_win: video_enable & X_OFF ≤ x_idx < X_OFF+IMG_W*scale_r & Y_OFF ≤ y_idx < Y_OFF+IMG_H*scale_r. Computed with IDX_W+3 bit arithmetic, no overflow.
- Column counters:
  - sub_x and col clear on the first in_win cycle of each line.
  - Each in_win cycle: bram_addr <= row_base+col, then sub_x++.
  - When sub_x==scale_r-1: sub_x wraps to 0 and col++.
- Row counters, on the last in_win cycle of a line (x_idx==X_OFF+IMG_W*scale_r-1):
  - sub_y++.
  - When sub_y==scale_r-1: sub_y wraps to 0 and row_base += IMG_W.
- No divider or multiplier on the address path; only adders and comparators.
- Outside the window, bram_addr holds its last value.
- Colour stage, selected by the delayed flags:
  - delayed video_enable=0: colour = 0.
  - delayed video_enable=1 and delayed in_win=0: colour = BORDER.
  - otherwise: colour = bram_data.
- h_sync_in, v_sync_in, video_enable and in_win pass through a shift register of depth L so they align with colour.

## Timing
- Latency L = BRAM_LAT+2 cycles, input sample to red/green/blue/h_sync/v_sync. Breakdown:
  - 1 cycle: address register.
  - BRAM_LAT cycles: BRAM read.
  - 1 cycle: colour register.
- Throughput is one pixel per clock with no stalls.
- frame_start asserts 1 cycle after the frame-start input cycle, i.e. together with bram_addr=0.
- Reset values:
  - red/green/blue = 0, bram_addr = 0, frame_start = 0.
  - h_sync/v_sync and the sync delay line = SYNC_RST.
  - scale_r = 1; all counters = 0; valid/in_win delay bits = 0.
- Reset mid-frame clears immediately (asynchronous). After release:
  - Colour stays 0 until the next frame start.
  - Syncs resume L cycles after the inputs.
- If the window is clipped by the visible area, the addresses that would exceed the screen are never issued. The next frame start re-synchronises all counters.
- Last address of a full frame is IMG_W*IMG_H-1. A wrap past this value is never generated.

## Test plan
- Scale=5, 384x216, zero offsets, 1920x1080 timing:
  - (0,0)->addr 0; (4,0)->0; (5,0)->1; (0,5)->384; (1919,1079)->82943.
  - Each address is output one cycle after its input.
- BRAM model with BRAM_LAT=2 returning data=address[11:0]:
  - RGB at input (5,0) equals 12'h001 exactly 4 cycles later.
  - h_sync/v_sync edges are shifted by exactly 4 cycles.
- X_OFF=64, Y_OFF=32, scale=1, BORDER=12'hF00:
  - x=63 -> colour F00; x=64,y=32 -> addr 0.
  - x=448 -> F00; blanking -> colour 000.
- scale changes 5->2 at y=500:
  - The current frame keeps 5-pixel replication.
  - The next frame start pulses frame_start and (2,0)->addr 1.
- scale=0: behaves identically to scale=1, i.e. (1,0)->addr 1.
- Reset asserted at (700,400) for 3 cycles:
  - Outputs go 0/SYNC_RST immediately.
  - After release, colour stays 0 until frame start; the first addr after frame start is 0.
